// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: BHT of 2-bit saturating counters combined with a BTB.
// Prediction is registered one cycle after fetch; execute-side updates also drive flush and statistics.
module branch_predictor #(
  parameter int         XLEN     = 32,
  parameter int         IDX_W    = 6,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [2:0]      ex_branch,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            ex_mispredict,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic            tbl_valid  [DEPTH];
  logic [TAG_W-1:0] tbl_tag   [DEPTH];
  logic            tbl_jump   [DEPTH];
  logic [1:0]      tbl_cnt    [DEPTH];
  logic [XLEN-1:0] tbl_target [DEPTH];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, if_taken, ex_hit, ex_is_branch;
  logic [XLEN-1:0]  if_next;

  logic             wr_en, wr_valid, wr_jump;
  logic [1:0]       wr_cnt;
  logic [XLEN-1:0]  wr_target;

  logic [31:0]      stat_branches_q, stat_mispred_q;
  logic             unused_pc_bits;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[XLEN-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[XLEN-1:IDX_W+2];
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  // Reads happen before this cycle's write lands, so a same-index fetch sees the old entry.
  assign if_hit   = tbl_valid[if_idx] && (tbl_tag[if_idx] == if_tag);
  assign if_taken = if_hit && (tbl_jump[if_idx] || tbl_cnt[if_idx][1]);
  assign if_next  = if_taken ? tbl_target[if_idx] : if_pc + XLEN'(4);

  assign ex_hit = tbl_valid[ex_idx] && (tbl_tag[ex_idx] == ex_tag);
  assign ex_is_branch = ex_valid && (ex_branch[2] || (ex_branch == 3'b001) || (ex_branch == 3'b010));

  assign ex_mispredict = ex_valid && rst_n &&
                         ((ex_pred_taken != ex_taken) ||
                          (ex_taken && (ex_pred_target != ex_target)));

  always_comb begin
    wr_en     = 1'b0;
    wr_valid  = 1'b1;
    wr_jump   = 1'b0;
    wr_cnt    = tbl_cnt[ex_idx];
    wr_target = tbl_target[ex_idx];
    if (ex_valid) begin
      case (ex_branch)
        3'b001, 3'b010: begin
          wr_en     = 1'b1;
          wr_jump   = 1'b1;
          wr_cnt    = 2'b11;
          wr_target = ex_target;
        end
        3'b000: begin
          // A non-branch hitting an entry means the entry aliases this PC; drop it.
          if (ex_hit) begin
            wr_en    = 1'b1;
            wr_valid = 1'b0;
            wr_jump  = tbl_jump[ex_idx];
          end
        end
        3'b011: wr_en = 1'b0;
        default: begin
          if (ex_hit) begin
            wr_en = 1'b1;
            if (ex_taken) begin
              wr_cnt    = (tbl_cnt[ex_idx] == 2'b11) ? 2'b11 : tbl_cnt[ex_idx] + 2'd1;
              wr_target = ex_target;
            end else begin
              wr_cnt = (tbl_cnt[ex_idx] == 2'b00) ? 2'b00 : tbl_cnt[ex_idx] - 2'd1;
            end
          end else if (ex_taken) begin
            wr_en     = 1'b1;
            wr_cnt    = 2'b10;
            wr_target = ex_target;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_valid[i] <= 1'b0;
        tbl_cnt[i]   <= CNT_INIT;
      end
    end else if (wr_en) begin
      tbl_valid[ex_idx] <= wr_valid;
      tbl_cnt[ex_idx]   <= wr_cnt;
    end
  end

  // Tag, type and target are only meaningful under a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      tbl_tag[ex_idx]    <= ex_tag;
      tbl_jump[ex_idx]   <= wr_jump;
      tbl_target[ex_idx] <= wr_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pred_valid      <= 1'b0;
      pred_taken      <= 1'b0;
      pred_target     <= '0;
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      pred_valid <= if_valid;
      if (if_valid) begin
        pred_taken  <= if_taken;
        pred_target <= if_next;
      end
      if (ex_is_branch && (stat_branches_q != 32'hFFFF_FFFF))
        stat_branches_q <= stat_branches_q + 32'd1;
      if (ex_mispredict && (stat_mispred_q != 32'hFFFF_FFFF))
        stat_mispred_q <= stat_mispred_q + 32'd1;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;

endmodule
